// File: rtl/alu_dp_pkg.sv
// Shared opcode encodings, flag bit positions and the flag-vector type for the ALU datapath.
package alu_dp_pkg;

    localparam logic [7:0] OpAdd = 8'h01;
    localparam logic [7:0] OpSub = 8'h02;
    localparam logic [7:0] OpAnd = 8'h03;
    localparam logic [7:0] OpOr  = 8'h04;
    localparam logic [7:0] OpXor = 8'h05;
    localparam logic [7:0] OpMov = 8'h06;
    localparam logic [7:0] OpShl = 8'h07;
    localparam logic [7:0] OpShr = 8'h08;
    localparam logic [7:0] OpCmp = 8'h09;

    // Bit positions within the packed {C, Z, N, V} flag vector.
    localparam int unsigned FlagC = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagV = 0;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: decodes the opcode, computes result and {C,Z,N,V},
// and reports whether the op is illegal and whether it writes a register.
module alu_core
    import alu_dp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags,
    output logic             illegal,
    output logic             writes
);

    localparam int unsigned Msb = WIDTH - 1;
    localparam int unsigned ShW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [ShW-1:0]   shamt;
    logic             carry;
    logic             ovf;

    assign sum   = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow out.
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[ShW-1:0];

    always_comb begin
        result  = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        writes  = 1'b1;
        case (opcode)
            OpAdd: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
            end
            OpSub, OpCmp: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
                writes = (opcode != OpCmp);
            end
            OpAnd: result = a & b;
            OpOr:  result = a | b;
            OpXor: result = a ^ b;
            OpMov: result = b;
            OpShl: result = a << shamt;
            OpShr: result = a >> shamt;
            default: begin
                illegal = 1'b1;
                writes  = 1'b0;
            end
        endcase
    end

    assign flags.c = carry;
    assign flags.z = (result == '0);
    assign flags.n = result[Msb];
    assign flags.v = ovf;

endmodule

// File: rtl/pipelined_alu_datapath.sv
// Two-stage ALU datapath with register file: S1 captures operands, S2 executes and writes back.
// Define ALU_FORWARD_EN to forward the S2 result into S1 instead of stalling on RAW hazards.
module pipelined_alu_datapath
    import alu_dp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 16,
    parameter int unsigned RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [7:0]       opcode,
    input  logic [RW-1:0]    rs_a,
    input  logic [RW-1:0]    rs_b,
    input  logic [RW-1:0]    rd,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] immediate,
    input  logic             bus_en,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal_op,
    output logic [WIDTH-1:0] result_bus
);

    logic [WIDTH-1:0] regs_q [NREGS];

    logic             s1_valid_q;
    logic [7:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [RW-1:0]    s1_rd_q;

    logic [WIDTH-1:0] result_q;
    alu_flags_t       flags_q;
    logic             result_valid_q;
    logic             illegal_q;

    logic [WIDTH-1:0] alu_result;
    alu_flags_t       alu_flags;
    logic             alu_illegal;
    logic             alu_writes;

    logic             hit_a;
    logic             hit_b;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .opcode  (s1_op_q),
        .a       (s1_a_q),
        .b       (s1_b_q),
        .result  (alu_result),
        .flags   (alu_flags),
        .illegal (alu_illegal),
        .writes  (alu_writes)
    );

    // RAW hazard: the op in S1 will write a register the incoming op reads.
    assign hit_a = s1_valid_q && alu_writes && (s1_rd_q == rs_a);
    assign hit_b = s1_valid_q && alu_writes && !imm_sel && (s1_rd_q == rs_b);

`ifdef ALU_FORWARD_EN
    assign issue_ready = 1'b1;
    assign op_a        = hit_a ? alu_result : regs_q[rs_a];
    assign op_b        = imm_sel ? immediate : (hit_b ? alu_result : regs_q[rs_b]);
`else
    // One bubble suffices: S1 drains at the next edge and the register file then holds the value.
    assign issue_ready = !(issue_valid && (hit_a || hit_b));
    assign op_a        = regs_q[rs_a];
    assign op_b        = imm_sel ? immediate : regs_q[rs_b];
`endif

    assign accept = issue_valid && issue_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_rd_q    <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_op_q <= opcode;
                s1_a_q  <= op_a;
                s1_b_q  <= op_b;
                s1_rd_q <= rd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (s1_valid_q && alu_writes) begin
            regs_q[s1_rd_q] <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_valid_q <= 1'b0;
            result_q       <= '0;
            flags_q        <= '0;
            illegal_q      <= 1'b0;
        end else begin
            result_valid_q <= s1_valid_q;
            illegal_q      <= s1_valid_q && alu_illegal;
            if (s1_valid_q) begin
                result_q <= alu_result;
                if (!alu_illegal) begin
                    flags_q <= alu_flags;
                end
            end
        end
    end

    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign illegal_op   = illegal_q;
    assign result_bus   = (result_valid_q && bus_en) ? result_q : '0;

endmodule

// File: doc/pipelined_alu_datapath.md
PIPELINED_ALU_DATAPATH -- requirements
Module: pipelined_alu_datapath

Interface
REQ-001 Parameter: WIDTH, 16, datapath and register width in bits.
REQ-002 Parameter: NREGS, 16, number of general registers; power of two, 2..32.
REQ-003 Parameter: RW, $clog2(NREGS), register-index width (derived).
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: issue_valid  input  1  instruction present.
REQ-007 Port: issue_ready  output  1  instruction accepted at this edge if issue_valid also high.
REQ-008 Port: opcode  input  8  operation select.
REQ-009 Port: rs_a, rs_b, rd  input  RW each  source A, source B, destination indices.
REQ-010 Port: imm_sel  input  1  operand B is immediate instead of register rs_b.
REQ-011 Port: immediate  input  WIDTH  immediate operand.
REQ-012 Port: bus_en  input  1  drive result_bus.
REQ-013 Port: result_valid  output  1  result and flags valid this cycle.
REQ-014 Port: result  output  WIDTH  registered ALU result.
REQ-015 Port: flags  output  4  {C, Z, N, V}, updated only on result_valid.
REQ-016 Port: illegal_op  output  1  pulse with result_valid for unknown opcode.
REQ-017 Port: result_bus  output  WIDTH  result when result_valid and bus_en, else all zeros (no tristate).

Function
REQ-018 Two stages: S1 operand capture at accept edge k; S2 execute, register result and write rd at edge k+1; result_valid high in cycle after edge k+1 (latency 2).
REQ-019 Throughput one instruction per cycle absent stalls; result_valid high exactly one cycle per instruction.
REQ-020 Opcodes: 0x01 ADD A+B; 0x02 SUB A-B; 0x03 AND; 0x04 OR; 0x05 XOR; 0x06 MOV result=B; 0x07 SHL A<<B[RW'...]; use B[$clog2(WIDTH)-1:0] as shift count; 0x08 SHR logical; 0x09 CMP flags of A-B, no write-back.
REQ-021 Any other opcode: result 0, no write-back, flags unchanged, illegal_op high with result_valid.
REQ-022 Arithmetic modulo 2^WIDTH; C = carry-out (ADD) or borrow (SUB, CMP); V = signed overflow; C, V cleared by logic/MOV/shift ops; Z, N from result (CMP: from difference).
REQ-023 Write-back to rd at edge k+1 for opcodes 0x01-0x08; S1 reads see register file value after that edge.
REQ-024 RAW hazard: S1 holds write-back op with rd equal to incoming rs_a, or to rs_b when imm_sel=0.
REQ-025 issue_ready is 1 except during a hazard stall (see Configuration); never depends on issue_valid combinationally beyond hazard compare.
REQ-026 Register 0 is a normal writable register.

Reset
REQ-027 reset low: all registers, result, flags, result_valid, illegal_op cleared to 0 immediately; in-flight S1/S2 instructions discarded, no write-back.
REQ-028 First edge after reset release accepts an instruction; issue_ready 1.

Configuration
REQ-029 Macro ALU_FORWARD_EN defined: on hazard the S2 ALU output is forwarded into S1 capture; no stall, back-to-back dependent ops at full rate.
REQ-030 ALU_FORWARD_EN undefined: on hazard issue_ready low for one cycle; dependent op accepted next edge reading written value.

Structure
REQ-031 Package alu_dp_pkg holds opcode constants, flag bit indices, and flags typedef.
REQ-032 Sub-module alu_core: purely combinational ALU (opcode, A, B -> result, flags, illegal, writes).

Verification
REQ-033 Reset, MOV imm 0x1234 to r3 -> result 0x1234 two cycles after accept, r3=0x1234, flags Z=0 N=0.
REQ-034 ADD 0xFFFF+0x0001 (WIDTH=16) -> result 0x0000, C=1 Z=1 V=0; ADD 0x7FFF+1 -> 0x8000, V=1 N=1.
REQ-035 MOV r1=5 then ADD r2=r1+r1 back-to-back -> r2=10; with ALU_FORWARD_EN no stall, without exactly one issue_ready=0 cycle.
REQ-036 CMP r1(5) vs imm 5 -> Z=1, C=0, register file unchanged; opcode 0xFF -> illegal_op pulse, flags held.
REQ-037 reset asserted between accept and result_valid -> no result_valid, destination register remains 0.
REQ-038 bus_en=0 -> result_bus 0 while result_valid high; bus_en=1 -> result_bus equals result.
